// File: rtl/systolic_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_feeder: loads W/X operands from memory into row buffers, then    |
// | streams one row per cycle to the systolic array. Rev 1.0                  |
// +--------------------------------------------------------------------------+
module systolic_feeder #(
  parameter int                    M           = 1,
  parameter int                    N           = 27,
  parameter int                    K           = 2,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h1000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter int                    DRAIN       = M + K - 1
) (
  input  logic                    clk,
  input  logic                    rst_systolic,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH*M-1:0] X,
  output logic [DATA_WIDTH*K-1:0] W,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int L    = N * (K + M);
  localparam int NK   = N * K;
  localparam int CMAX = (L > N) ? ((L > DRAIN) ? L : DRAIN) : ((N > DRAIN) ? N : DRAIN);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam int LMAX = (K > M) ? K : M;
  localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  localparam logic [CW-1:0] L_LAST  = CW'(L - 1);
  localparam logic [CW-1:0] NK_C    = CW'(NK);
  localparam logic [CW-1:0] NK_LAST = CW'(NK - 1);
  localparam logic [CW-1:0] N_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] D_LAST  = CW'((DRAIN > 0) ? DRAIN - 1 : 0);
  localparam logic [LW-1:0] K_LAST  = LW'(K - 1);
  localparam logic [LW-1:0] M_LAST  = LW'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    issue_vld_q, issue_vld_d;
  logic                    cap_vld_q, cap_vld_d;
  logic [CW-1:0]           cap_idx_q, cap_idx_d;
  logic [RW-1:0]           cap_row_q, cap_row_d;
  logic [LW-1:0]           cap_lane_q, cap_lane_d;
  logic [DATA_WIDTH*K-1:0] w_hold_q, w_hold_d;
  logic [DATA_WIDTH*K-1:0] wbuf_q [N];
  logic [DATA_WIDTH*K-1:0] wbuf_d [N];
  logic [DATA_WIDTH*M-1:0] xbuf_q [N];
  logic [DATA_WIDTH*M-1:0] xbuf_d [N];
  logic [RW-1:0]           beat_row;

  assign beat_row = cnt_q[RW-1:0];
  assign rd_addr  = rd_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign valid    = (state_q == S_STREAM);
  assign done     = (state_q == S_FIN);
  assign X        = valid ? xbuf_q[beat_row] : '0;
  assign W        = valid ? wbuf_q[beat_row] : w_hold_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_nxt     = cnt_q + CW'(1);
    rd_addr_d   = rd_addr_q;
    issue_vld_d = 1'b0;
    cap_vld_d   = 1'b0;
    cap_idx_d   = cap_idx_q;
    cap_row_d   = cap_row_q;
    cap_lane_d  = cap_lane_q;
    w_hold_d    = w_hold_q;
    wbuf_d      = wbuf_q;
    xbuf_d      = xbuf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          cnt_d       = '0;
          rd_addr_d   = WEIGHT_BASE;
          issue_vld_d = 1'b1;
          cap_row_d   = '0;
          cap_lane_d  = '0;
          w_hold_d    = '0;
        end
      end

      S_LOAD: begin
        // Issue side: cnt_q is the index of the address currently on rd_addr.
        if (issue_vld_q && (cnt_q != L_LAST)) begin
          cnt_d       = cnt_nxt;
          issue_vld_d = 1'b1;
          rd_addr_d   = (cnt_nxt < NK_C) ? WEIGHT_BASE + ADDR_WIDTH'(cnt_nxt)
                                         : IM2COL_BASE + ADDR_WIDTH'(cnt_nxt - NK_C);
        end
        cap_vld_d = issue_vld_q;
        cap_idx_d = cnt_q;

        // Capture side lags the issue by one cycle (synchronous read latency).
        if (cap_vld_q) begin
          if (cap_idx_q < NK_C) begin
            wbuf_d[cap_row_q][int'(cap_lane_q)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
            if (cap_lane_q == K_LAST) begin
              cap_lane_d = '0;
              cap_row_d  = cap_row_q + RW'(1);
            end else begin
              cap_lane_d = cap_lane_q + LW'(1);
            end
            if (cap_idx_q == NK_LAST) begin
              cap_lane_d = '0;
              cap_row_d  = '0;
            end
          end else begin
            xbuf_d[cap_row_q][int'(cap_lane_q)*DATA_WIDTH +: DATA_WIDTH] = rd_data;
            if (cap_lane_q == M_LAST) begin
              cap_lane_d = '0;
              cap_row_d  = cap_row_q + RW'(1);
            end else begin
              cap_lane_d = cap_lane_q + LW'(1);
            end
          end
          if (cap_idx_q == L_LAST) begin
            state_d = S_STREAM;
            cnt_d   = '0;
          end
        end
      end

      S_STREAM: begin
        w_hold_d = wbuf_q[beat_row];
        if (cnt_q == N_LAST) begin
          cnt_d   = '0;
          state_d = (DRAIN == 0) ? S_FIN : S_DRAIN;
        end else begin
          cnt_d = cnt_nxt;
        end
      end

      S_DRAIN: begin
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_nxt;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_systolic) begin
    if (!rst_systolic) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      issue_vld_q <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      cap_row_q   <= '0;
      cap_lane_q  <= '0;
      w_hold_q    <= '0;
      for (int i = 0; i < N; i++) begin
        wbuf_q[i] <= '0;
        xbuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      issue_vld_q <= issue_vld_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
      cap_row_q   <= cap_row_d;
      cap_lane_q  <= cap_lane_d;
      w_hold_q    <= w_hold_d;
      wbuf_q      <= wbuf_d;
      xbuf_q      <= xbuf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_systolic_feeder: directed bench for systolic_feeder (small + default). |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_systolic = 1'b0;
  always #5 clk = ~clk;

  logic            start_a = 1'b0;
  logic [AW-1:0]   rd_addr_a;
  logic [DW-1:0]   rd_data_a;
  logic [2*DW-1:0] x_a;
  logic [2*DW-1:0] w_a;
  logic            valid_a, busy_a, done_a;

  logic            start_b = 1'b0;
  logic [AW-1:0]   rd_addr_b;
  logic [DW-1:0]   rd_data_b;
  logic [DW-1:0]   x_b;
  logic [2*DW-1:0] w_b;
  logic            valid_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.M(2), .N(3), .K(2)) dut_a (
    .clk(clk), .rst_systolic(rst_systolic), .start(start_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .X(x_a), .W(w_a),
    .valid(valid_a), .busy(busy_a), .done(done_a)
  );

  systolic_feeder dut_b (
    .clk(clk), .rst_systolic(rst_systolic), .start(start_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .X(x_b), .W(w_b),
    .valid(valid_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a >= 32'h2000 && a < 32'h2100) return 32'hB0 + (a - 32'h2000);
    if (a >= 32'h1000 && a < 32'h1100) return 32'hA0 + (a - 32'h1000);
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    rd_data_a <= mem_rd(rd_addr_a);
    rd_data_b <= mem_rd(rd_addr_b);
  end

  // Two-lane beat t: {base+2t+1, base+2t}, upper lane first.
  function automatic logic [2*DW-1:0] pair(input logic [DW-1:0] base, input int t);
    return {base + 32'(2*t + 1), base + 32'(2*t)};
  endfunction

  task automatic run_a(input int ncyc, input int rp1, input int rp2,
                       output int nvalid, output int first_valid,
                       output int done_cyc, output int ndone, output int nbad);
    nvalid = 0; first_valid = -1; done_cyc = -1; ndone = 0; nbad = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (valid_a === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (x_a !== pair(32'hB0, nvalid % 3) || w_a !== pair(32'hA0, nvalid % 3)) nbad++;
        nvalid++;
      end
      if (done_a === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      start_a = (cyc == rp1) || (cyc == rp2);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({x_a, w_a, rd_addr_a} !== '0) begin
      errors++;
      $display("FAIL reset_a_data: X=%h W=%h rd_addr=%h, expected all zero", x_a, w_a, rd_addr_a);
    end
    checks++;
    if ({valid_a, busy_a, done_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_a_ctrl: valid/busy/done=%b, expected 000", {valid_a, busy_a, done_a});
    end
    checks++;
    if ({x_b, w_b, rd_addr_b, valid_b, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: X=%h W=%h rd_addr=%h vbd=%b, expected all zero",
               x_b, w_b, rd_addr_b, {valid_b, busy_b, done_b});
    end
    rst_systolic = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic          ev, ed, eb;
    logic [AW-1:0] ea;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      ev = (cyc >= 14 && cyc <= 16);
      ed = (cyc == 20);
      eb = (cyc <= 20);
      checks++;
      if ({valid_a, done_a, busy_a} !== {ev, ed, eb}) begin
        errors++;
        $display("FAIL basic_ctrl cyc %0d: valid/done/busy=%b, expected %b",
                 cyc, {valid_a, done_a, busy_a}, {ev, ed, eb});
      end
      if (cyc <= 12) begin
        ea = (cyc <= 6) ? 32'h1000 + 32'(cyc - 1) : 32'h2000 + 32'(cyc - 7);
        checks++;
        if (rd_addr_a !== ea) begin
          errors++;
          $display("FAIL basic_addr cyc %0d: rd_addr=%h, expected %h", cyc, rd_addr_a, ea);
        end
      end
      if (ev) begin
        checks++;
        if (x_a !== pair(32'hB0, cyc - 14) || w_a !== pair(32'hA0, cyc - 14)) begin
          errors++;
          $display("FAIL basic_beat cyc %0d: X=%h W=%h, expected X=%h W=%h", cyc, x_a, w_a,
                   pair(32'hB0, cyc - 14), pair(32'hA0, cyc - 14));
        end
      end else if (cyc >= 17 && cyc <= 19) begin
        checks++;
        if (x_a !== '0 || w_a !== {32'hA5, 32'hA4}) begin
          errors++;
          $display("FAIL basic_drain cyc %0d: X=%h W=%h, expected X=0 W=000000a5000000a4",
                   cyc, x_a, w_a);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_default();
    int nvalid, ndone, done_cyc, nbad;
    nvalid = 0; ndone = 0; done_cyc = -1; nbad = 0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      if (valid_b === 1'b1) begin
        if (x_b !== 32'hB0 + 32'(nvalid) || w_b !== pair(32'hA0, nvalid)) nbad++;
        nvalid++;
      end
      if (done_b === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      @(negedge clk);
    end
    checks++;
    if (nvalid !== 27) begin
      errors++; $display("FAIL default_beats: got %0d, expected 27", nvalid);
    end
    checks++;
    if (done_cyc !== 112 || ndone !== 1) begin
      errors++; $display("FAIL default_done: cycle %0d count %0d, expected cycle 112 count 1", done_cyc, ndone);
    end
    checks++;
    if (nbad !== 0) begin
      errors++; $display("FAIL default_data: %0d bad beats, expected 0", nbad);
    end
    checks++;
    if (w_b !== {32'hA0 + 32'd53, 32'hA0 + 32'd52} || x_b !== '0) begin
      errors++; $display("FAIL default_w_hold: W=%h X=%h, expected W=000000d5000000d4 X=0", w_b, x_b);
    end
  endtask

  task automatic test_start_ignored();
    int nv, fv, dc, nd, nb;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    run_a(30, 5, 15, nv, fv, dc, nd, nb);
    checks++;
    if (nv !== 3 || fv !== 14) begin
      errors++; $display("FAIL ignored_beats: count %0d first %0d, expected 3 at 14", nv, fv);
    end
    checks++;
    if (dc !== 20 || nd !== 1) begin
      errors++; $display("FAIL ignored_done: cycle %0d count %0d, expected cycle 20 count 1", dc, nd);
    end
    checks++;
    if (nb !== 0) begin
      errors++; $display("FAIL ignored_data: %0d bad beats, expected 0", nb);
    end
  endtask

  task automatic test_reset_mid();
    int nv, fv, dc, nd, nb;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || x_a !== pair(32'hB0, 1)) begin
      errors++; $display("FAIL midrst_pre: valid=%b X=%h, expected valid=1 X=%h", valid_a, x_a, pair(32'hB0, 1));
    end
    #1 rst_systolic = 1'b0;
    #1;
    checks++;
    if ({x_a, w_a, valid_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL midrst_async: X=%h W=%h vbd=%b, expected all zero", x_a, w_a, {valid_a, busy_a, done_a});
    end
    @(negedge clk) rst_systolic = 1'b1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    run_a(24, 0, 0, nv, fv, dc, nd, nb);
    checks++;
    if (nv !== 3 || fv !== 14 || nb !== 0) begin
      errors++; $display("FAIL midrst_rerun: beats %0d first %0d bad %0d, expected 3/14/0", nv, fv, nb);
    end
    checks++;
    if (dc !== 20 || nd !== 1) begin
      errors++; $display("FAIL midrst_done: cycle %0d count %0d, expected cycle 20 count 1", dc, nd);
    end
  endtask

  task automatic test_back_to_back();
    logic ev, ed;
    int   t, nbad;
    nbad = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      ev = (cyc >= 14 && cyc <= 16) || (cyc >= 35 && cyc <= 37);
      ed = (cyc == 20) || (cyc == 41);
      checks++;
      if ({valid_a, done_a} !== {ev, ed}) begin
        errors++;
        $display("FAIL b2b_ctrl cyc %0d: valid/done=%b, expected %b", cyc, {valid_a, done_a}, {ev, ed});
      end
      if (ev) begin
        t = (cyc < 30) ? cyc - 14 : cyc - 35;
        if (x_a !== pair(32'hB0, t) || w_a !== pair(32'hA0, t)) nbad++;
      end
      if (cyc == 21) begin
        checks++;
        if (busy_a !== 1'b0) begin
          errors++; $display("FAIL b2b_idle cyc 21: busy=%b, expected 0", busy_a);
        end
      end
      if (cyc == 22) begin
        checks++;
        if (rd_addr_a !== 32'h1000 || busy_a !== 1'b1) begin
          errors++; $display("FAIL b2b_relaunch cyc 22: rd_addr=%h busy=%b, expected 00001000 1", rd_addr_a, busy_a);
        end
      end
      if (cyc == 30) start_a = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (nbad !== 0) begin
      errors++; $display("FAIL b2b_data: %0d bad beats, expected 0", nbad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_default();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
